// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and event bundle for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_IGN_00 = 8'h00;
    localparam logic [7:0] PS2_IGN_AA = 8'hAA;
    localparam logic [7:0] PS2_IGN_EE = 8'hEE;
    localparam logic [7:0] PS2_IGN_FA = 8'hFA;
    localparam logic [7:0] PS2_IGN_FC = 8'hFC;
    localparam logic [7:0] PS2_IGN_FD = 8'hFD;
    localparam logic [7:0] PS2_IGN_FE = 8'hFE;
    localparam logic [7:0] PS2_IGN_FF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_IGN_00) || (b == PS2_IGN_AA) ||
               (b == PS2_IGN_EE) || (b == PS2_IGN_FA) ||
               (b == PS2_IGN_FC) || (b == PS2_IGN_FD) ||
               (b == PS2_IGN_FE) || (b == PS2_IGN_FF);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; head output holds the last popped
// event while empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output evt_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    evt_t           mem [DEPTH];
    evt_t           last;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_pop;
    logic           do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code prefix decoder feeding an event FIFO.
// Optional typematic repeat suppression: PS2_REPEAT_FILTER_EN.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAUSE_LEN = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       evt_ovf
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       emit;
    logic       push;
    evt_t       evt;
    evt_t       head;
    logic       full;
    logic       empty;
    logic       ign;
    logic       pfx;

    assign ign = is_ignored(byte_data);
    assign pfx = is_prefix(byte_data);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        evt       = '0;
        if (byte_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_nxt = ST_BRK;
                    end else if (byte_data == PS2_PAUSE) begin
                        state_nxt = ST_PAUSE;
                        cnt_nxt   = '0;
                    end else if (!ign) begin
                        emit = 1'b1;
                        evt  = '{code: byte_data, ext: 1'b0, brk: 1'b0};
                    end
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (byte_data != PS2_EXT) begin
                        state_nxt = ST_IDLE;
                        emit      = !ign;
                        evt       = '{code: byte_data, ext: 1'b1, brk: 1'b0};
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    emit      = !ign && !pfx;
                    evt       = '{code: byte_data, ext: 1'b0, brk: 1'b1};
                end
                ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    emit      = !ign && !pfx;
                    evt       = '{code: byte_data, ext: 1'b1, brk: 1'b1};
                end
                ST_PAUSE: begin
                    // the pause body is swallowed blind; only its length matters
                    if (cnt == 8'(PAUSE_LEN - 1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        emit      = 1'b1;
                        evt       = '{code: PS2_PAUSE, ext: 1'b1, brk: 1'b0};
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held;
    logic [7:0] held_code;
    logic       held_ext;
    logic       match;

    assign match = held && (held_code == evt.code) && (held_ext == evt.ext);
    assign push  = emit && !(match && !evt.brk);

    always_ff @(posedge clk) begin
        if (!reset) begin
            held      <= 1'b0;
            held_code <= '0;
            held_ext  <= 1'b0;
        end else if (emit) begin
            if (evt.brk) begin
                if (match) held <= 1'b0;
            end else if (!match) begin
                held      <= 1'b1;
                held_code <= evt.code;
                held_ext  <= evt.ext;
            end
        end
    end
`else
    assign push = emit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            evt_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (push && full && !evt_ready) evt_ovf <= 1'b1;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (evt),
        .pop   (evt_ready),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_valid = !empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_brk   = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed plus randomized byte streams checked cycle by cycle against a
// queue-based model of the decoder and its event FIFO.
module tb_ps2_scancode_decoder;

    localparam int DEPTH     = 4;
    localparam int PAUSE_LEN = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_ovf;

    ps2_scancode_decoder #(
        .DEPTH     (DEPTH),
        .PAUSE_LEN (PAUSE_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .evt_ovf    (evt_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [7:0] code;
        bit       ext;
        bit       brk;
    } ev_t;

    ev_t q[$];
    ev_t last;
    bit  m_ovf;
    bit  m_ext;
    bit  m_brk;
    int  m_pause;
    bit  m_held;
    ev_t m_hkey;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic bit ignored(input bit [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE,
                         8'hFF};
    endfunction

    function automatic void model_reset();
        q.delete();
        last    = '{8'h00, 1'b0, 1'b0};
        m_ovf   = 0;
        m_ext   = 0;
        m_brk   = 0;
        m_pause = 0;
        m_held  = 0;
    endfunction

    function automatic void model_emit(input bit [7:0] c, input bit e,
                                       input bit b);
        ev_t ev;
        ev = '{c, e, b};
`ifdef PS2_REPEAT_FILTER_EN
        if (!b) begin
            if (m_held && m_hkey.code == c && m_hkey.ext == e) return;
            m_held = 1;
            m_hkey = ev;
        end else if (m_held && m_hkey.code == c && m_hkey.ext == e) begin
            m_held = 0;
        end
`endif
        if (q.size() < DEPTH) q.push_back(ev);
        else m_ovf = 1;
    endfunction

    // prefix bytes accumulate as flags; the pause body is a countdown
    function automatic void model_byte(input bit [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_emit(8'hE1, 1, 0);
        end else if (ignored(b)) begin
            m_ext = 0;
            m_brk = 0;
        end else if (m_brk) begin
            if (!(b inside {8'hE0, 8'hF0, 8'hE1})) model_emit(b, m_ext, 1);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1 && !m_ext) begin
            m_pause = PAUSE_LEN;
        end else begin
            model_emit(b, m_ext, 0);
            m_ext = 0;
        end
    endfunction

    task automatic compare();
        ev_t h;
        h = (q.size() > 0) ? q[0] : last;
        chk("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
        chk("evt_code", 32'(evt_code), 32'(h.code));
        chk("evt_ext", 32'(evt_ext), 32'(h.ext));
        chk("evt_brk", 32'(evt_brk), 32'(h.brk));
        chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
    endtask

    task automatic step(input bit bv, input bit [7:0] bd, input bit rdy);
        compare();
        byte_valid = bv;
        byte_data  = bd;
        evt_ready  = rdy;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (rdy && q.size() > 0) last = q.pop_front();
            if (bv) model_byte(bd);
        end
        @(negedge clk);
    endtask

    task automatic send(input bit [7:0] b);
        step(1, b, 1);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(0, 8'h00, rdy);
    endtask

    initial begin
        bit [7:0] codes[6];
        bit [7:0] ign[8];
        codes = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'h15, 8'h16};
        ign   = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        evt_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        send(8'h1C); idle(2, 1);
        send(8'hF0); send(8'h1C); idle(2, 1);
        send(8'hE0); send(8'h75); idle(2, 1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2, 1);
        foreach (codes[i]) if (i < 4) send(i[0] ? 8'hF0 : 8'h00);
        idle(1, 1);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(2, 1);
        send(8'h1C); idle(2, 1);

        step(1, 8'h15, 0); step(1, 8'h16, 0); step(1, 8'h1E, 0);
        step(1, 8'h26, 0); step(1, 8'h25, 0);
        idle(2, 0);
        idle(6, 1);

        send(8'hE0); send(8'hFA); send(8'h1C); idle(2, 1);
        send(8'hF0);
        reset = 1'b0;
        idle(1, 1);
        reset = 1'b1;
        send(8'h1C); idle(2, 1);

        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        idle(4, 1);

        for (int c = 0; c < 1500; c++) begin
            int r;
            bit [7:0] b;
            r = $urandom_range(0, 11);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
                3: b = ign[$urandom_range(0, 7)];
                4: b = 8'($urandom);
                default: b = codes[$urandom_range(0, 5)];
            endcase
            if (c == 700) reset = 1'b0;
            step(1'($urandom_range(0, 2) != 0), b,
                 1'($urandom_range(0, 3) != 0));
            reset = 1'b1;
        end
        idle(8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
